// File: rtl/combo_solver_pkg.sv
// Shared definitions for the light/button combination solvers:
// FSM state encoding, count-width helper and popcount.
package combo_solver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_DONE
    } state_t;

    // Bits needed to hold a press count of 0..max_buttons.
    function automatic int cw_width(input int max_buttons);
        return $clog2(max_buttons + 1);
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/combo_lane_eval.sv
// One evaluation lane: XOR of the buttons selected by a subset mask,
// compared against the target, plus the subset's press count.
module combo_lane_eval
    import combo_solver_pkg::*;
#(
    parameter int MAX_LIGHT_COUNT  = 10,
    parameter int MAX_BUTTON_COUNT = 13,
    parameter int CW               = cw_width(MAX_BUTTON_COUNT)
) (
    input  logic [MAX_BUTTON_COUNT-1:0]                 subset,
    input  logic [MAX_LIGHT_COUNT*MAX_BUTTON_COUNT-1:0] buttons,
    input  logic [MAX_LIGHT_COUNT-1:0]                  target,
    input  logic                                        lane_en,
    output logic                                        match,
    output logic [CW-1:0]                               press_count
);

    logic [MAX_LIGHT_COUNT-1:0] lights;

    always_comb begin
        lights = '0;
        for (int unsigned i = 0; i < MAX_BUTTON_COUNT; i++) begin
            if (subset[i]) begin
                lights = lights ^ buttons[i*MAX_LIGHT_COUNT +: MAX_LIGHT_COUNT];
            end
        end
    end

    assign match       = lane_en && (lights == target);
    assign press_count = CW'(popcount(32'(subset)));

endmodule

// File: rtl/combo_solver_multilane.sv
// Multi-lane combination solver: sweeps all button subsets LANES at a time
// and reports the minimum-press matching subset over a valid/ready handshake.
module combo_solver_multilane
    import combo_solver_pkg::*;
#(
    parameter int MAX_LIGHT_COUNT  = 10,
    parameter int MAX_BUTTON_COUNT = 13,
    parameter int LANES            = 4,
    parameter int EARLY_EXIT       = 1,
    localparam int CW              = cw_width(MAX_BUTTON_COUNT)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [MAX_LIGHT_COUNT*MAX_BUTTON_COUNT-1:0] buttons_flattened,
    input  logic [MAX_LIGHT_COUNT-1:0]                  expect_lights,
    input  logic [CW-1:0]                               num_buttons,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [CW-1:0]                               min_presses,
    output logic [MAX_BUTTON_COUNT-1:0]                 best_mask,
    output logic                                        found
);

    localparam int MBC = MAX_BUTTON_COUNT;
    localparam int MLC = MAX_LIGHT_COUNT;

    state_t               state;
    logic [MBC:0]         base;
    logic [CW-1:0]        n_reg;
    logic [MLC*MBC-1:0]   btn_reg;
    logic [MLC-1:0]       target_reg;

    logic [CW-1:0]        n_clamp;
    logic [MLC*MBC-1:0]   btn_masked;
    logic [MBC:0]         limit;

    logic [MBC:0]         lane_s     [LANES];
    logic                 lane_match [LANES];
    logic [CW-1:0]        lane_cnt   [LANES];

    logic                 sel_hit;
    logic [CW-1:0]        sel_cnt;
    logic [MBC-1:0]       sel_mask;
    logic                 improve;
    logic [CW-1:0]        next_best_cnt;
    logic [MBC+1:0]       next_base_ext;
    logic                 last_chunk;
    logic                 early_stop;

    // Buttons beyond the in-use count are zeroed at capture so the lanes never see them.
    always_comb begin
        n_clamp    = (num_buttons > CW'(MBC)) ? CW'(MBC) : num_buttons;
        btn_masked = '0;
        for (int unsigned i = 0; i < MBC; i++) begin
            if (i < 32'(n_clamp)) begin
                btn_masked[i*MLC +: MLC] = buttons_flattened[i*MLC +: MLC];
            end
        end
    end

    assign limit = (MBC+1)'(1) << n_reg;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_s[g] = base + (MBC+1)'(g);

        combo_lane_eval #(
            .MAX_LIGHT_COUNT  (MLC),
            .MAX_BUTTON_COUNT (MBC),
            .CW               (CW)
        ) u_lane (
            .subset      (lane_s[g][MBC-1:0]),
            .buttons     (btn_reg),
            .target      (target_reg),
            .lane_en     (lane_s[g] < limit),
            .match       (lane_match[g]),
            .press_count (lane_cnt[g])
        );
    end

    // Strict less-than keeps the lowest-index lane on popcount ties.
    always_comb begin
        sel_hit  = 1'b0;
        sel_cnt  = CW'(MBC);
        sel_mask = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (lane_match[j] && (!sel_hit || (lane_cnt[j] < sel_cnt))) begin
                sel_hit  = 1'b1;
                sel_cnt  = lane_cnt[j];
                sel_mask = lane_s[j][MBC-1:0];
            end
        end
    end

    assign improve       = sel_hit && (sel_cnt < min_presses);
    assign next_best_cnt = improve ? sel_cnt : min_presses;
    assign next_base_ext = {1'b0, base} + (MBC+2)'(LANES);
    assign last_chunk    = next_base_ext >= {1'b0, limit};
    assign early_stop    = (EARLY_EXIT != 0) && (next_best_cnt <= CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            min_presses <= '0;
            best_mask   <= '0;
            found       <= 1'b0;
            base        <= '0;
            n_reg       <= '0;
            btn_reg     <= '0;
            target_reg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        btn_reg     <= btn_masked;
                        target_reg  <= expect_lights;
                        n_reg       <= n_clamp;
                        base        <= '0;
                        min_presses <= CW'(MBC);
                        best_mask   <= '0;
                        found       <= 1'b0;
                        in_ready    <= 1'b0;
                        state       <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (improve) begin
                        min_presses <= sel_cnt;
                        best_mask   <= sel_mask;
                        found       <= 1'b1;
                    end
                    base <= base + (MBC+1)'(LANES);
                    if (last_chunk || early_stop) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_combo_solver_multilane.sv
// Scoreboard bench: four solver instances (different LANES/EARLY_EXIT) run the
// same jobs; expected results come from a chunked software reference.
module tb_combo_solver_multilane;

    localparam int MLC    = 10;
    localparam int MBC    = 13;
    localparam int CW     = 4;
    localparam int ND     = 4;
    localparam int BUDGET = 9000;

    typedef logic [MLC-1:0] btn_arr_t [MBC];

    typedef struct {
        int             dut;
        logic           fnd;
        logic [CW-1:0]  cnt;
        logic [MBC-1:0] mask;
        int             cycles;
    } exp_t;

    function automatic int lanes_of(input int d);
        case (d)
            0: return 4;
            1: return 4;
            2: return 1;
            default: return 16;
        endcase
    endfunction

    function automatic int ee_of(input int d);
        return (d == 0 || d == 2) ? 1 : 0;
    endfunction

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [MLC*MBC-1:0]   buttons_flattened;
    logic [MLC-1:0]       expect_lights;
    logic [CW-1:0]        num_buttons;
    logic                 out_ready;

    logic                 ir [ND];
    logic                 ov [ND];
    logic [CW-1:0]        mp [ND];
    logic [MBC-1:0]       bm [ND];
    logic                 fd [ND];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        combo_solver_multilane #(
            .MAX_LIGHT_COUNT  (MLC),
            .MAX_BUTTON_COUNT (MBC),
            .LANES            (lanes_of(g)),
            .EARLY_EXIT       (ee_of(g))
        ) dut (
            .clk               (clk),
            .reset             (reset),
            .in_valid          (in_valid),
            .in_ready          (ir[g]),
            .buttons_flattened (buttons_flattened),
            .expect_lights     (expect_lights),
            .num_buttons       (num_buttons),
            .out_valid         (ov[g]),
            .out_ready         (out_ready),
            .min_presses       (mp[g]),
            .best_mask         (bm[g]),
            .found             (fd[g])
        );
    end

    function automatic exp_t model(input int d, input btn_arr_t b,
                                   input logic [MLC-1:0] tgt, input int nb);
        exp_t e;
        int n, lanes, total, s, pc;
        logic [MLC-1:0] lights;
        n     = (nb > MBC) ? MBC : nb;
        lanes = lanes_of(d);
        total = 1 << n;
        e.dut = d; e.fnd = 1'b0; e.cnt = CW'(MBC); e.mask = '0; e.cycles = 0;
        for (int c = 0; c * lanes < total; c++) begin
            for (int j = 0; j < lanes; j++) begin
                s = c * lanes + j;
                if (s < total) begin
                    lights = '0;
                    pc = 0;
                    for (int i = 0; i < n; i++) begin
                        if (s[i]) begin
                            lights = lights ^ b[i];
                            pc++;
                        end
                    end
                    if (lights == tgt && pc < int'(e.cnt)) begin
                        e.fnd  = 1'b1;
                        e.cnt  = CW'(pc);
                        e.mask = MBC'(s);
                    end
                end
            end
            e.cycles = c + 1;
            if (ee_of(d) != 0 && e.cnt <= 1) break;
        end
        return e;
    endfunction

    task automatic run_job(input btn_arr_t b, input logic [MLC-1:0] tgt,
                           input logic [CW-1:0] nb, input int hold, input string tag);
        int got [ND];
        int cyc;
        bit all_seen;
        logic [CW-1:0]  s_mp [ND];
        logic [MBC-1:0] s_bm [ND];
        logic           s_fd [ND];
        exp_t e;

        for (int d = 0; d < ND; d++) sbq.push_back(model(d, b, tgt, int'(nb)));
        for (int i = 0; i < MBC; i++) buttons_flattened[i*MLC +: MLC] = b[i];
        expect_lights = tgt;
        num_buttons   = nb;
        for (int d = 0; d < ND; d++) begin
            n_tests++;
            if (ir[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s idle_in_ready dut%0d: got %b expected 1", tag, d, ir[d]);
            end
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid          = 1'b0;
        buttons_flattened = {$urandom, $urandom, $urandom, $urandom, $urandom};
        expect_lights     = MLC'($urandom);
        num_buttons       = CW'($urandom);
        for (int d = 0; d < ND; d++) begin
            got[d] = -1;
            n_tests++;
            if (ir[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_in_ready dut%0d: got %b expected 0", tag, d, ir[d]);
            end
        end

        cyc = 0;
        all_seen = 1'b0;
        while (!all_seen && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            all_seen = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (got[d] < 0 && ov[d] === 1'b1) got[d] = cyc;
                if (got[d] < 0) all_seen = 1'b0;
            end
        end

        for (int d = 0; d < ND; d++) begin
            s_mp[d] = mp[d]; s_bm[d] = bm[d]; s_fd[d] = fd[d];
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            for (int d = 0; d < ND; d++) begin
                n_tests++;
                if (ov[d] !== 1'b1 || ir[d] !== 1'b0 || mp[d] !== s_mp[d] ||
                    bm[d] !== s_bm[d] || fd[d] !== s_fd[d]) begin
                    n_fail++;
                    $display("FAIL %s hold_stable dut%0d: got ov=%b ir=%b mp=%0d bm=%h fd=%b expected ov=1 ir=0 mp=%0d bm=%h fd=%b",
                             tag, d, ov[d], ir[d], mp[d], bm[d], fd[d], s_mp[d], s_bm[d], s_fd[d]);
                end
            end
        end

        for (int d = 0; d < ND; d++) begin
            e = sbq.pop_front();
            n_tests++;
            if (got[d] != e.cycles) begin
                n_fail++;
                $display("FAIL %s latency dut%0d: got %0d expected %0d", tag, e.dut, got[d], e.cycles);
            end
            n_tests++;
            if (fd[d] !== e.fnd) begin
                n_fail++;
                $display("FAIL %s found dut%0d: got %b expected %b", tag, e.dut, fd[d], e.fnd);
            end
            n_tests++;
            if (mp[d] !== e.cnt) begin
                n_fail++;
                $display("FAIL %s min_presses dut%0d: got %0d expected %0d", tag, e.dut, mp[d], e.cnt);
            end
            n_tests++;
            if (bm[d] !== e.mask) begin
                n_fail++;
                $display("FAIL %s best_mask dut%0d: got %h expected %h", tag, e.dut, bm[d], e.mask);
            end
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int d = 0; d < ND; d++) begin
            n_tests++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s release dut%0d: got ir=%b ov=%b expected ir=1 ov=0", tag, d, ir[d], ov[d]);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < ND; d++) begin
            n_tests++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || mp[d] !== '0 || bm[d] !== '0 || fd[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d: got ir=%b ov=%b mp=%0d bm=%h fd=%b expected ir=1 ov=0 mp=0 bm=0 fd=0",
                         tag, d, ir[d], ov[d], mp[d], bm[d], fd[d]);
            end
        end
    endtask

    function automatic btn_arr_t zero_btns();
        btn_arr_t b;
        for (int i = 0; i < MBC; i++) b[i] = '0;
        return b;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        buttons_flattened = '0; expect_lights = '0; num_buttons = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_values");
        reset = 1'b0;
    endtask

    task automatic test_basic();
        btn_arr_t b = zero_btns();
        b[0] = 10'b0011; b[1] = 10'b0110; b[2] = 10'b1100;
        run_job(b, 10'b0101, 4'd3, 0, "basic");
    endtask

    task automatic test_zero_target();
        btn_arr_t b = zero_btns();
        b[0] = 10'h2A5; b[1] = 10'h013; b[2] = 10'h3C0; b[3] = 10'h001;
        run_job(b, '0, 4'd4, 0, "zero_target");
        run_job(b, '0, 4'd0, 0, "n_zero");
    endtask

    task automatic test_not_found();
        btn_arr_t b = zero_btns();
        b[0] = 10'b01; b[1] = 10'b01;
        run_job(b, 10'b10, 4'd2, 0, "not_found");
        b = zero_btns();
        b[0] = 10'b001; b[1] = 10'b010; b[2] = 10'b100;
        run_job(b, 10'b100, 4'd2, 0, "masked_button");
    endtask

    task automatic test_tie();
        btn_arr_t b = zero_btns();
        b[0] = 10'b1; b[1] = 10'b1; b[2] = 10'b1;
        run_job(b, 10'b1, 4'd3, 0, "tie");
    endtask

    task automatic test_clamp();
        btn_arr_t b;
        for (int i = 0; i < MBC - 1; i++) b[i] = MLC'(1 << (i % 9));
        b[MBC-1] = 10'h200;
        run_job(b, 10'h200, 4'd15, 0, "clamp");
    endtask

    task automatic test_back_to_back();
        btn_arr_t b = zero_btns();
        b[0] = 10'h00F; b[1] = 10'h0F0; b[2] = 10'h3C3; b[3] = 10'h111;
        run_job(b, 10'h0FF, 4'd4, 5, "backpressure");
        b[4] = 10'h2EE;
        run_job(b, 10'h3FF, 4'd5, 1, "second_job");
    endtask

    task automatic test_reset_mid();
        btn_arr_t b = zero_btns();
        for (int i = 0; i < MBC; i++) b[i] = MLC'(1 << (i % 9));
        for (int i = 0; i < MBC; i++) buttons_flattened[i*MLC +: MLC] = b[i];
        expect_lights = 10'h200;
        num_buttons   = 4'd13;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_state("reset_mid");
        reset = 1'b0;
        b = zero_btns();
        b[0] = 10'h011; b[1] = 10'h022; b[2] = 10'h033;
        run_job(b, 10'h033, 4'd3, 0, "after_reset");
    endtask

    task automatic test_random();
        btn_arr_t b;
        logic [MLC-1:0] tgt;
        int n;
        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(0, 9);
            for (int i = 0; i < MBC; i++) b[i] = MLC'($urandom);
            tgt = MLC'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                tgt = '0;
                for (int i = 0; i < n; i++) if ($urandom_range(0, 1) == 1) tgt = tgt ^ b[i];
            end
            run_job(b, tgt, CW'(n), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_target();
        test_not_found();
        test_tie();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
